// File: rtl/freq_meter.sv
// Reciprocal frequency meter: counts whole input periods over a >= GATE_CYCLES gate,
// then serially divides rises*CLK_HZ by gate length to report Hz, last period and no-signal.
module freq_meter #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        sig_in,
  input  logic        start,
  input  logic        cont,
  output logic        busy,
  output logic        valid,
  output logic [31:0] freq_hz,
  output logic [31:0] period_clks,
  output logic        no_sig
);

  localparam logic [31:0] GATE_L = 32'(GATE_CYCLES);
  localparam logic [31:0] TMO_L  = 32'(TIMEOUT_CYC);
  localparam logic [63:0] CLK_L  = 64'(CLK_HZ);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_GATE, S_DIV, S_DONE} state_t;

  state_t      state_q;
  logic        s1_q, s2_q, s3_q;
  logic [31:0] tmr_q, m_q, p_q, n_q, plast_q, mf_q, rem_q;
  logic [63:0] num_q;
  logic [5:0]  cnt_q;
  logic        busy_q, valid_q, nosig_q;
  logic [31:0] freq_q, per_q;

  logic        rise;
  logic [31:0] m_inc_d, p_inc_d;
  logic [63:0] numer_d;
  logic [32:0] trial_d, diff_d;
  logic        qbit_d;
  logic [31:0] rem_d;
  logic [63:0] num_d;

  always_comb begin
    rise    = s2_q & ~s3_q;
    m_inc_d = m_q + 32'd1;
    p_inc_d = p_q + 32'd1;
    numer_d = 64'(n_q + 32'd1) * CLK_L;
    // Remainder stays below the divisor, so the 33-bit trial minus the divisor
    // never exceeds 32 bits and its MSB is a clean borrow flag.
    trial_d = {rem_q, num_q[63]};
    diff_d  = trial_d - {1'b0, mf_q};
    qbit_d  = ~diff_d[32];
    rem_d   = qbit_d ? diff_d[31:0] : trial_d[31:0];
    num_d   = {num_q[62:0], qbit_d};
  end

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      tmr_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      n_q     <= '0;
      plast_q <= '0;
      mf_q    <= '0;
      rem_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      nosig_q <= 1'b0;
      freq_q  <= '0;
      per_q   <= '0;
    end else begin
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start | cont) begin
            state_q <= S_ARM;
            tmr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          tmr_q <= tmr_q + 32'd1;
          if (rise) begin
            state_q <= S_GATE;
            m_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
          end else if (tmr_q == TMO_L - 32'd1) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            nosig_q <= 1'b1;
            freq_q  <= '0;
            per_q   <= '0;
          end
        end
        S_GATE: begin
          m_q <= m_inc_d;
          p_q <= p_inc_d;
          if (rise) begin
            n_q     <= n_q + 32'd1;
            plast_q <= p_inc_d;
            p_q     <= '0;
            if (m_inc_d >= GATE_L) begin
              state_q <= S_DIV;
              mf_q    <= m_inc_d;
              num_q   <= numer_d;
              rem_q   <= '0;
              cnt_q   <= '0;
            end
          end else if (m_inc_d == TMO_L) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            nosig_q <= 1'b1;
            freq_q  <= '0;
            per_q   <= '0;
          end
        end
        S_DIV: begin
          num_q <= num_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            nosig_q <= 1'b0;
            freq_q  <= (num_d[63:32] != 32'd0) ? 32'hFFFF_FFFF : num_d[31:0];
            per_q   <= plast_q;
          end
        end
        S_DONE: begin
          if (cont) begin
            state_q <= S_ARM;
            tmr_q   <= '0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign valid       = valid_q;
  assign freq_hz     = freq_q;
  assign period_clks = per_q;
  assign no_sig      = nosig_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a shortened gate/timeout; expected values hand-computed
// as floor(CLK_HZ / period) since every gate spans a whole number of input periods.
module tb_freq_meter;
  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned GATE   = 1000;
  localparam int unsigned TMO    = 2500;
  localparam int          LIM    = 20000;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b0, sig_in = 1'b0, start = 1'b0, cont = 1'b0;
  logic        busy, valid, no_sig;
  logic [31:0] freq_hz, period_clks;

  int n_cmp = 0, n_bad = 0;
  int hi = 1, lo = 1;
  bit gen_en = 1'b0;
  logic man_sig = 1'b0;
  int vcount = 0;

  freq_meter #(.CLK_HZ(CLK_HZ), .GATE_CYCLES(GATE), .TIMEOUT_CYC(TMO)) dut (
    .clk_50M(clk_50M), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy), .valid(valid), .freq_hz(freq_hz), .period_clks(period_clks), .no_sig(no_sig)
  );

  always #10 clk_50M = ~clk_50M;

  initial begin : gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk_50M);
      if (!gen_en) begin
        ph = 0;
        sig_in = man_sig;
      end else begin
        sig_in = (ph < hi);
        ph = (ph + 1 >= hi + lo) ? 0 : ph + 1;
      end
    end
  end

  always @(posedge clk_50M) begin
    #1;
    if (valid) vcount++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk_50M) start = 1'b1;
    @(negedge clk_50M) start = 1'b0;
  endtask

  task automatic wait_valid(output int w);
    w = 0;
    while (!valid && w < LIM) begin
      @(negedge clk_50M);
      w++;
    end
    if (!valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: no valid within %0d cycles", LIM);
    end
  endtask

  task automatic set_wave(input int h, input int l);
    gen_en = 1'b0;
    @(negedge clk_50M);
    hi = h;
    lo = l;
    gen_en = 1'b1;
    repeat (20) @(negedge clk_50M);
  endtask

  typedef struct {
    int          hi;
    int          lo;
    logic [31:0] f;
    logic [31:0] p;
  } vec_t;
  vec_t vt[8];

  initial begin
    int w, v0;
    vt[0] = '{3,   2,   32'd10_000_000, 32'd5};
    vt[1] = '{1,   1,   32'd25_000_000, 32'd2};
    vt[2] = '{500, 500, 32'd50_000,     32'd1000};
    vt[3] = '{567, 567, 32'd44_091,     32'd1134};
    vt[4] = '{4,   3,   32'd7_142_857,  32'd7};
    vt[5] = '{750, 750, 32'd33_333,     32'd1500};
    vt[6] = '{2,   1,   32'd16_666_666, 32'd3};
    vt[7] = '{300, 300, 32'd83_333,     32'd600};

    repeat (3) @(negedge clk_50M);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_freq", freq_hz, 32'd0);
    chk("rst_period", period_clks, 32'd0);
    chk("rst_nosig", 32'(no_sig), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      set_wave(vt[i].hi, vt[i].lo);
      do_start();
      wait_valid(w);
      chk($sformatf("v%0d_freq", i), freq_hz, vt[i].f);
      chk($sformatf("v%0d_period", i), period_clks, vt[i].p);
      chk($sformatf("v%0d_nosig", i), 32'(no_sig), 32'd0);
      @(negedge clk_50M);
      chk($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
    end

    // No edges at all: timeout from ARM, valid exactly TMO cycles after ARM entry.
    gen_en = 1'b0;
    man_sig = 1'b0;
    repeat (10) @(negedge clk_50M);
    do_start();
    wait_valid(w);
    chk("arm_tmo_lat", w, TMO);
    chk("arm_tmo_nosig", 32'(no_sig), 32'd1);
    chk("arm_tmo_freq", freq_hz, 32'd0);
    chk("arm_tmo_period", period_clks, 32'd0);

    // A single edge opens the gate but nothing closes it.
    repeat (5) @(negedge clk_50M);
    do_start();
    repeat (10) @(negedge clk_50M);
    man_sig = 1'b1;
    repeat (3) @(negedge clk_50M);
    man_sig = 1'b0;
    v0 = vcount;
    wait_valid(w);
    chk("gate_tmo_nosig", 32'(no_sig), 32'd1);
    chk("gate_tmo_freq", freq_hz, 32'd0);
    chk("gate_tmo_lat_min", 32'(w > 2000), 32'd1);

    // Recovery after no-signal.
    set_wave(500, 500);
    do_start();
    wait_valid(w);
    chk("recov_nosig", 32'(no_sig), 32'd0);
    chk("recov_freq", freq_hz, 32'd50_000);
    chk("recov_period", period_clks, 32'd1000);

    // Starts while busy must not produce extra results.
    repeat (5) @(negedge clk_50M);
    v0 = vcount;
    do_start();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_50M);
      start = busy && (i % 97 == 0);
    end
    start = 1'b0;
    chk("busy_one_valid", vcount - v0, 32'd1);
    chk("busy_idle_end", 32'(busy), 32'd0);

    // Continuous mode: back-to-back results.
    v0 = vcount;
    cont = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(w);
      chk($sformatf("cont%0d_freq", k), freq_hz, 32'd50_000);
      chk($sformatf("cont%0d_period", k), period_clks, 32'd1000);
      if (k == 2) cont = 1'b0;
      @(negedge clk_50M);
      chk($sformatf("cont%0d_busy", k), 32'(busy), (k == 2) ? 32'd0 : 32'd1);
    end
    chk("cont_count", vcount - v0, 32'd3);

    // Reset in the middle of a gate.
    set_wave(3, 2);
    cont = 1'b1;
    repeat (500) @(negedge clk_50M);
    rst = 1'b0;
    @(negedge clk_50M);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_freq", freq_hz, 32'd0);
    chk("mid_rst_period", period_clks, 32'd0);
    chk("mid_rst_nosig", 32'(no_sig), 32'd0);
    cont = 1'b0;
    @(negedge clk_50M) rst = 1'b1;
    v0 = vcount;
    repeat (3000) @(negedge clk_50M);
    chk("post_rst_no_valid", vcount - v0, 32'd0);
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
